// File: rtl/b01_word_sink.sv
`default_nettype none
// ============================================================================
// Module      : b01_word_sink
// Description : Consumer for the b01 serial comparator/adder stage. Samples
//               OUTP/OVERFLW in fixed WORD_BITS-cycle frames, reassembles
//               LSB-first words tagged with the frame's overflow flag, queues
//               them in a small FIFO behind a valid/ready port, and keeps
//               saturating overflow/drop counters plus a sticky protocol
//               error flag.
//               Optional macro B01_WORD_SINK_PARITY_EN adds PAR_IN/WORD_PAR
//               (word parity carried through the FIFO and checked on entry).
// Revision    : 1.0 - initial release
// ============================================================================
module b01_word_sink #(
  parameter int WORD_BITS  = 4,
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 IN_VALID,
  input  logic                 OUTP,
  input  logic                 OVERFLW,
`ifdef B01_WORD_SINK_PARITY_EN
  input  logic                 PAR_IN,
  output logic                 WORD_PAR,
`endif
  output logic [WORD_BITS-1:0] WORD_DATA,
  output logic                 WORD_OVF,
  output logic                 WORD_VALID,
  input  logic                 WORD_READY,
  output logic [CNT_W-1:0]     OVF_CNT,
  output logic [CNT_W-1:0]     DROP_CNT,
  output logic                 PROTO_ERR
);

  localparam int PH_W  = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(WORD_BITS - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  // Frame collection state
  logic [PH_W-1:0]      phase;
  logic [WORD_BITS-1:0] shreg;
  logic                 cur_ovf;

  // Word FIFO storage, pointers and explicit fill level
  logic [WORD_BITS-1:0]  mem_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] mem_ovf;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [LVL_W-1:0]      level;

  // Statistics
  logic [CNT_W-1:0] ovf_cnt;
  logic [CNT_W-1:0] drop_cnt;
  logic             proto_err;

  logic                 at_first;
  logic                 at_last;
  logic                 complete;
  logic                 non_empty;
  logic                 full;
  logic                 pop;
  logic                 push;
  logic                 drop;
  logic                 phase_err;
  logic                 par_err;
  logic [WORD_BITS-1:0] done_word;

  assign at_first  = (phase == '0);
  assign at_last   = (phase == PH_LAST);
  assign complete  = IN_VALID && at_last;
  assign non_empty = (level != '0);
  assign full      = (level == LVL_FULL);
  // A pop on the completion edge frees the slot the new word needs.
  assign pop       = non_empty && WORD_READY;
  assign push      = complete && (!full || pop);
  assign drop      = complete && full && !pop;
  // OVERFLW is only legal on the first bit of a frame.
  assign phase_err = IN_VALID && OVERFLW && !at_first;

  // Completed word: earlier bits from the assembly register, top bit live.
  always_comb begin
    done_word                = shreg;
    done_word[WORD_BITS-1]   = OUTP;
  end

`ifdef B01_WORD_SINK_PARITY_EN
  logic                  done_par;
  logic [FIFO_DEPTH-1:0] mem_par;

  assign done_par = (^done_word) ^ cur_ovf;
  assign par_err  = complete && (PAR_IN != done_par);
  assign WORD_PAR = non_empty ? mem_par[rd_ptr] : 1'b0;

  // Parity travels through the FIFO alongside its word.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_par <= '0;
    end else if (push) begin
      mem_par[wr_ptr] <= done_par;
    end
  end
`else
  assign par_err = 1'b0;
`endif

  // Phase counter and LSB-first word assembly; frozen while IN_VALID is low.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      phase   <= '0;
      shreg   <= '0;
      cur_ovf <= 1'b0;
    end else if (IN_VALID) begin
      phase <= at_last ? '0 : phase + PH_W'(1);
      if (at_first) begin
        shreg   <= WORD_BITS'(OUTP);
        cur_ovf <= OVERFLW;
      end else begin
        shreg[phase] <= OUTP;
      end
    end
  end

  // FIFO storage, wrapping pointers and level tracking.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_data[i] <= '0;
      end
      mem_ovf <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      level   <= '0;
    end else begin
      if (push) begin
        mem_data[wr_ptr] <= done_word;
        mem_ovf[wr_ptr]  <= cur_ovf;
        wr_ptr           <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        level <= level + LVL_W'(1);
      end else if (pop && !push) begin
        level <= level - LVL_W'(1);
      end
    end
  end

  // Saturating statistics and sticky protocol error.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ovf_cnt   <= '0;
      drop_cnt  <= '0;
      proto_err <= 1'b0;
    end else begin
      if (push && cur_ovf && (ovf_cnt != CNT_MAX)) begin
        ovf_cnt <= ovf_cnt + CNT_W'(1);
      end
      if (drop && (drop_cnt != CNT_MAX)) begin
        drop_cnt <= drop_cnt + CNT_W'(1);
      end
      if (phase_err || par_err) begin
        proto_err <= 1'b1;
      end
    end
  end

  assign WORD_VALID = non_empty;
  assign WORD_DATA  = non_empty ? mem_data[rd_ptr] : '0;
  assign WORD_OVF   = non_empty ? mem_ovf[rd_ptr] : 1'b0;
  assign OVF_CNT    = ovf_cnt;
  assign DROP_CNT   = drop_cnt;
  assign PROTO_ERR  = proto_err;

endmodule
`default_nettype wire

// File: tb/tb_b01_word_sink.sv
`default_nettype none
// ============================================================================
// Module      : tb_b01_word_sink
// Description : Self-checking bench for b01_word_sink (default build).
//               Directed scenarios plus a randomized run, all checked against
//               a queue-based behavioural model of the word sink.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_b01_word_sink;

  localparam int WB    = 4;
  localparam int DEPTH = 2;
  localparam int CW    = 8;
  localparam int SAT   = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          IN_VALID = 1'b0;
  logic          OUTP = 1'b0;
  logic          OVERFLW = 1'b0;
  logic          WORD_READY = 1'b0;
  logic [WB-1:0] WORD_DATA;
  logic          WORD_OVF;
  logic          WORD_VALID;
  logic [CW-1:0] OVF_CNT;
  logic [CW-1:0] DROP_CNT;
  logic          PROTO_ERR;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int m_phase;
  int m_bits;
  bit m_ovf;
  int q_data[$];
  bit q_ovf[$];
  int m_ovf_cnt;
  int m_drop_cnt;
  bit m_proto;

  b01_word_sink #(.WORD_BITS(WB), .FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .IN_VALID   (IN_VALID),
    .OUTP       (OUTP),
    .OVERFLW    (OVERFLW),
    .WORD_DATA  (WORD_DATA),
    .WORD_OVF   (WORD_OVF),
    .WORD_VALID (WORD_VALID),
    .WORD_READY (WORD_READY),
    .OVF_CNT    (OVF_CNT),
    .DROP_CNT   (DROP_CNT),
    .PROTO_ERR  (PROTO_ERR)
  );

  always #5 clock = ~clock;

  task automatic model_reset();
    m_phase = 0; m_bits = 0; m_ovf = 0;
    q_data.delete(); q_ovf.delete();
    m_ovf_cnt = 0; m_drop_cnt = 0; m_proto = 0;
  endtask

  // Drive one clock's inputs, advance the model on the edge, return at negedge.
  task automatic cycle(input bit inv, input bit outp, input bit ovf, input bit rdy);
    int dummy;
    bit dummyb;
    IN_VALID = inv; OUTP = outp; OVERFLW = ovf; WORD_READY = rdy;
    @(posedge clock);
    if (q_data.size() != 0 && rdy) begin
      dummy  = q_data.pop_front();
      dummyb = q_ovf.pop_front();
    end
    if (inv) begin
      if (m_phase == 0) begin
        m_bits = 0;
        m_ovf  = ovf;
      end else if (ovf) begin
        m_proto = 1;
      end
      if (outp) m_bits += (1 << m_phase);
      if (m_phase == WB - 1) begin
        if (q_data.size() < DEPTH) begin
          q_data.push_back(m_bits);
          q_ovf.push_back(m_ovf);
          if (m_ovf && m_ovf_cnt < SAT) m_ovf_cnt++;
        end else if (m_drop_cnt < SAT) begin
          m_drop_cnt++;
        end
      end
      m_phase = (m_phase + 1) % WB;
    end
    @(negedge clock);
  endtask

  task automatic send_frame(input int bits, input bit ovf, input bit rdy);
    for (int i = 0; i < WB; i++) begin
      cycle(1'b1, bit'((bits >> i) & 1), (i == 0) ? ovf : 1'b0, rdy);
    end
  endtask

  task automatic reset_dut();
    IN_VALID = 0; OUTP = 0; OVERFLW = 0; WORD_READY = 0;
    reset_n = 0;
    model_reset();
    @(negedge clock);
    @(negedge clock);
    reset_n = 1;
  endtask

  task automatic test_reset();
    reset_dut();
    checks++; if (WORD_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", WORD_VALID); end
    checks++; if (WORD_DATA !== '0) begin errors++; $display("FAIL reset_data: got %0h expected 0", WORD_DATA); end
    checks++; if (WORD_OVF !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %0b expected 0", WORD_OVF); end
    checks++; if (OVF_CNT !== '0) begin errors++; $display("FAIL reset_ovf_cnt: got %0d expected 0", OVF_CNT); end
    checks++; if (DROP_CNT !== '0) begin errors++; $display("FAIL reset_drop_cnt: got %0d expected 0", DROP_CNT); end
    checks++; if (PROTO_ERR !== 1'b0) begin errors++; $display("FAIL reset_proto: got %0b expected 0", PROTO_ERR); end
  endtask

  task automatic test_basic_word();
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(4'b1101, 1'b0, 1'b1);
    checks++; if (WORD_VALID !== 1'b1) begin errors++; $display("FAIL basic_valid: got %0b expected 1", WORD_VALID); end
    checks++; if (WORD_DATA !== 4'b1101 || q_data.size() != 1 || WORD_DATA !== WB'(q_data[0])) begin errors++; $display("FAIL basic_data: got %0h expected d", WORD_DATA); end
    checks++; if (WORD_OVF !== 1'b0) begin errors++; $display("FAIL basic_ovf: got %0b expected 0", WORD_OVF); end
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (WORD_VALID !== 1'b0) begin errors++; $display("FAIL basic_popped: got %0b expected 0", WORD_VALID); end
    checks++; if (OVF_CNT !== CW'(m_ovf_cnt) || m_ovf_cnt != 0) begin errors++; $display("FAIL basic_ovf_cnt: got %0d expected 0", OVF_CNT); end
  endtask

  task automatic test_overflow_tag();
    send_frame(4'b1000, 1'b1, 1'b1);
    checks++; if (WORD_DATA !== 4'b1000) begin errors++; $display("FAIL ovf_data: got %0h expected 8", WORD_DATA); end
    checks++; if (WORD_OVF !== 1'b1) begin errors++; $display("FAIL ovf_tag: got %0b expected 1", WORD_OVF); end
    checks++; if (OVF_CNT !== CW'(1)) begin errors++; $display("FAIL ovf_cnt: got %0d expected 1", OVF_CNT); end
    checks++; if (PROTO_ERR !== 1'b0) begin errors++; $display("FAIL ovf_proto: got %0b expected 0", PROTO_ERR); end
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_backpressure();
    int w[3];
    reset_dut();
    for (int i = 0; i < 3; i++) begin
      w[i] = $urandom_range(0, 15);
      send_frame(w[i], 1'b0, 1'b0);
    end
    checks++; if (WORD_VALID !== 1'b1 || WORD_DATA !== WB'(w[0])) begin errors++; $display("FAIL bp_head: got v=%0b d=%0h expected v=1 d=%0h", WORD_VALID, WORD_DATA, w[0]); end
    checks++; if (DROP_CNT !== CW'(1)) begin errors++; $display("FAIL bp_drop: got %0d expected 1", DROP_CNT); end
    for (int i = 0; i < 2; i++) begin
      checks++; if (WORD_VALID !== 1'b1 || WORD_DATA !== WB'(w[i])) begin errors++; $display("FAIL bp_order%0d: got v=%0b d=%0h expected v=1 d=%0h", i, WORD_VALID, WORD_DATA, w[i]); end
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
    end
    checks++; if (WORD_VALID !== 1'b0) begin errors++; $display("FAIL bp_empty: got %0b expected 0", WORD_VALID); end
  endtask

  task automatic test_full_with_pop();
    int w[3];
    for (int i = 0; i < 3; i++) w[i] = $urandom_range(0, 15);
    send_frame(w[0], 1'b0, 1'b0);
    send_frame(w[1], 1'b0, 1'b0);
    for (int i = 0; i < WB; i++) begin
      cycle(1'b1, bit'((w[2] >> i) & 1), 1'b0, i == WB - 1);
    end
    checks++; if (DROP_CNT !== CW'(1)) begin errors++; $display("FAIL fullpop_drop: got %0d expected 1", DROP_CNT); end
    for (int i = 1; i < 3; i++) begin
      checks++; if (WORD_VALID !== 1'b1 || WORD_DATA !== WB'(w[i])) begin errors++; $display("FAIL fullpop_order%0d: got v=%0b d=%0h expected v=1 d=%0h", i, WORD_VALID, WORD_DATA, w[i]); end
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
    end
    checks++; if (WORD_VALID !== 1'b0) begin errors++; $display("FAIL fullpop_empty: got %0b expected 0", WORD_VALID); end
  endtask

  task automatic test_proto_gap();
    reset_dut();
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0);
    checks++; if (PROTO_ERR !== 1'b0) begin errors++; $display("FAIL gap_proto_idle: got %0b expected 0", PROTO_ERR); end
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    checks++; if (PROTO_ERR !== 1'b1) begin errors++; $display("FAIL gap_proto_set: got %0b expected 1", PROTO_ERR); end
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (WORD_VALID !== 1'b1 || WORD_DATA !== 4'b0101 || WORD_OVF !== 1'b0) begin errors++; $display("FAIL gap_word: got v=%0b d=%0h o=%0b expected v=1 d=5 o=0", WORD_VALID, WORD_DATA, WORD_OVF); end
    send_frame(4'b0011, 1'b0, 1'b1);
    checks++; if (PROTO_ERR !== 1'b1) begin errors++; $display("FAIL gap_proto_sticky: got %0b expected 1", PROTO_ERR); end
  endtask

  task automatic test_reset_midframe();
    int w;
    reset_dut();
    send_frame(4'b0110, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    checks++; if (OVF_CNT !== CW'(1) || WORD_VALID !== 1'b1) begin errors++; $display("FAIL mid_pre: got cnt=%0d v=%0b expected cnt=1 v=1", OVF_CNT, WORD_VALID); end
    reset_n = 0;
    model_reset();
    #1;
    checks++; if (WORD_VALID !== 1'b0 || WORD_DATA !== '0 || WORD_OVF !== 1'b0) begin errors++; $display("FAIL mid_async_out: got v=%0b d=%0h o=%0b expected 0", WORD_VALID, WORD_DATA, WORD_OVF); end
    checks++; if (OVF_CNT !== '0 || DROP_CNT !== '0) begin errors++; $display("FAIL mid_async_cnt: got ovf=%0d drop=%0d expected 0", OVF_CNT, DROP_CNT); end
    @(negedge clock);
    reset_n = 1;
    w = $urandom_range(0, 15);
    send_frame(w, 1'b0, 1'b0);
    checks++; if (WORD_VALID !== 1'b1 || WORD_DATA !== WB'(w)) begin errors++; $display("FAIL mid_new_word: got v=%0b d=%0h expected v=1 d=%0h", WORD_VALID, WORD_DATA, w); end
  endtask

  task automatic test_saturation();
    reset_dut();
    for (int i = 0; i < 260; i++) send_frame($urandom_range(0, 15), 1'b1, 1'b1);
    checks++; if (OVF_CNT !== CW'(SAT)) begin errors++; $display("FAIL sat_ovf: got %0d expected %0d", OVF_CNT, SAT); end
    for (int i = 0; i < 260; i++) send_frame($urandom_range(0, 15), 1'b1, 1'b0);
    checks++; if (DROP_CNT !== CW'(SAT)) begin errors++; $display("FAIL sat_drop: got %0d expected %0d", DROP_CNT, SAT); end
    checks++; if (OVF_CNT !== CW'(SAT)) begin errors++; $display("FAIL sat_ovf_hold: got %0d expected %0d", OVF_CNT, SAT); end
  endtask

  task automatic test_random();
    int exp_data;
    bit exp_ovf;
    bit inv, ovf;
    reset_dut();
    for (int n = 0; n < 3000; n++) begin
      inv = ($urandom_range(0, 9) != 0);
      if (m_phase == 0) ovf = ($urandom_range(0, 3) == 0);
      else              ovf = ($urandom_range(0, 199) == 0);
      cycle(inv, bit'($urandom_range(0, 1)), ovf, bit'($urandom_range(0, 2) == 0));
      exp_data = (q_data.size() != 0) ? q_data[0] : 0;
      exp_ovf  = (q_data.size() != 0) ? q_ovf[0] : 1'b0;
      checks++; if (WORD_VALID !== (q_data.size() != 0)) begin errors++; $display("FAIL rnd_valid@%0d: got %0b expected %0b", n, WORD_VALID, q_data.size() != 0); end
      checks++; if (WORD_DATA !== WB'(exp_data)) begin errors++; $display("FAIL rnd_data@%0d: got %0h expected %0h", n, WORD_DATA, exp_data); end
      checks++; if (WORD_OVF !== exp_ovf) begin errors++; $display("FAIL rnd_ovf@%0d: got %0b expected %0b", n, WORD_OVF, exp_ovf); end
      checks++; if (OVF_CNT !== CW'(m_ovf_cnt)) begin errors++; $display("FAIL rnd_ovf_cnt@%0d: got %0d expected %0d", n, OVF_CNT, m_ovf_cnt); end
      checks++; if (DROP_CNT !== CW'(m_drop_cnt)) begin errors++; $display("FAIL rnd_drop_cnt@%0d: got %0d expected %0d", n, DROP_CNT, m_drop_cnt); end
      checks++; if (PROTO_ERR !== m_proto) begin errors++; $display("FAIL rnd_proto@%0d: got %0b expected %0b", n, PROTO_ERR, m_proto); end
    end
  endtask

  initial begin
    test_reset();
    test_basic_word();
    test_overflow_tag();
    test_backpressure();
    test_full_with_pop();
    test_proto_gap();
    test_reset_midframe();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/b01_word_sink.md
Name: b01_word_sink

Overview:
- Downstream consumer of the b01 serial comparator/adder stage.
- b01 emits one OUTP bit per clock in fixed 4-cycle frames. OVERFLW marks frame start after a carry-out (state e).
- This block samples OUTP/OVERFLW, reassembles frame-aligned words LSB-first, and tags each word with its overflow flag.
- Words are buffered in a small FIFO and presented on a valid/ready port; overflow, drop and protocol-error statistics are kept.

Parameters:
- WORD_BITS, 4, bits per frame; must equal the b01 frame period (4).
- FIFO_DEPTH, 2, word FIFO entries; legal range 1..8.
- CNT_W, 8, width of the saturating statistics counters.

Ports:
- clock  in  1  rising-edge clock, shared with b01.
- reset_n  in  1  asynchronous, active-low reset.
- IN_VALID  in  1  sample enable; high on every cycle b01 OUTP/OVERFLW hold a fresh result (integrator drives 0 for the first cycle after reset, then 1).
- OUTP  in  1  serial result bit from b01.
- OVERFLW  in  1  overflow flag from b01.
- WORD_DATA  out  WORD_BITS  head-of-FIFO word; bit 0 = first sampled bit.
- WORD_OVF  out  1  overflow tag of the head word.
- WORD_VALID  out  1  FIFO non-empty.
- WORD_READY  in  1  consumer accepts the head word when high together with WORD_VALID.
- OVF_CNT  out  CNT_W  count of words tagged overflow; saturating.
- DROP_CNT  out  CNT_W  count of words lost to a full FIFO; saturating.
- PROTO_ERR  out  1  sticky; OVERFLW was seen high off frame phase 0.

Behaviour:
- Reset (reset_n=0, asynchronous): phase=0, shift register=0, FIFO empty, all outputs 0 (WORD_DATA=0, WORD_OVF=0, WORD_VALID=0, OVF_CNT=0, DROP_CNT=0, PROTO_ERR=0).
- Reset mid-frame discards the partial word and all FIFO contents. The first sample after release is phase 0.
- Phase counter: 0..WORD_BITS-1; advances only on edges with IN_VALID=1; wraps WORD_BITS-1 -> 0. IN_VALID=0 freezes all collection state.
- Collect: on a sampled edge, OUTP is written into bit [phase] of the assembly register.
  - At phase 0 the register is cleared first, except bit 0 which takes OUTP.
  - At phase 0, OVERFLW is captured as the word's ovf tag.
- Protocol check: a sampled OVERFLW=1 at phase != 0 sets PROTO_ERR. It stays set until reset. The word is not affected.
- Completion: the sample at phase WORD_BITS-1 completes the word {ovf, bits}, which is pushed on that same edge.
  - WORD_VALID rises on that edge if the FIFO was empty, so output latency is 1 clock after the last bit's sampling edge.
  - OVF_CNT increments on push of a word with ovf=1; saturates at all-ones.
- Pop: on an edge with WORD_VALID=1 and WORD_READY=1, the head is removed. WORD_DATA/WORD_OVF are stable while WORD_VALID=1 and WORD_READY=0. WORD_DATA/WORD_OVF show 0 when empty.
- Simultaneous push and pop:
  - FIFO non-empty: level unchanged, order preserved.
  - FIFO full: the pop frees a slot and the push is accepted, with no drop.
  - FIFO empty: no pop occurs (WORD_VALID=0); the push is accepted.
- Full, no pop: the completed word is discarded and DROP_CNT increments (saturating). The discarded word does not touch OVF_CNT. Collection of the next frame continues normally.
- FIFO pointers wrap modulo FIFO_DEPTH. Level is tracked explicitly so full and empty are unambiguous for any depth 1..8.

Optional Feature:
- Macro: B01_WORD_SINK_PARITY_EN.
- Defined:
  - Adds output WORD_PAR (1 bit) = XOR of WORD_DATA bits and WORD_OVF for the head word. It is stored in the FIFO with the word and is 0 when empty/reset.
  - Adds input PAR_IN (1 bit), sampled with OUTP at phase WORD_BITS-1. On mismatch with the computed word parity, PROTO_ERR is set; the word is still pushed.
- Undefined: neither port exists; PROTO_ERR reflects only the OVERFLW phase check.

Test Plan:
- Reset, IN_VALID=1, WORD_READY=1, OUTP sequence 1,0,1,1, OVERFLW=0 -> one clock after the 4th sample, WORD_VALID=1, WORD_DATA=4'b1101, WORD_OVF=0; popped next edge; OVF_CNT=0.
- OVERFLW=1 at phase 0 only, OUTP=0,0,0,1 -> WORD_DATA=4'b1000, WORD_OVF=1, OVF_CNT=1, PROTO_ERR=0.
- WORD_READY=0, 3 full frames with FIFO_DEPTH=2 -> WORD_VALID=1, head = first word, DROP_CNT=1; release WORD_READY -> words 1 and 2 delivered in order, then WORD_VALID=0.
- FIFO full and WORD_READY=1 on the completion edge of a new word -> DROP_CNT unchanged, level stays 2, new word delivered third.
- OVERFLW=1 at phase 2; IN_VALID=0 for 3 cycles mid-frame -> PROTO_ERR=1 and sticky; frozen phase resumes, and the word assembles correctly across the gap.
- Assert reset_n=0 after 2 bits of a frame with 1 word queued -> WORD_VALID=0 and counters 0 immediately. After release, the next 4 samples form a new word starting at bit 0.
